// File: rtl/encoder_8to3_irq.sv
// Sequential 8-to-3 priority encoder with request/acknowledge handshake.
// Pending lines accumulate; the highest unmasked one is granted until ACK.
module encoder_8to3_irq (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] REQ_IN,
  input  logic [7:0] MASK,
  input  logic       ACK,
  output logic [2:0] ENC_OUT,
  output logic       VALID,
  output logic [7:0] PENDING
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] enc_q, enc_d;
  logic       valid_q, valid_d;
  logic [7:0] pend_q, pend_d;

  logic [7:0] elig;
  logic [7:0] clr;
  logic [2:0] top_idx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      enc_q   <= 3'd0;
      valid_q <= 1'b0;
      pend_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      enc_q   <= enc_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  // Registered pending only; REQ_IN never bypasses arbitration.
  always_comb begin
    elig    = pend_q & ~MASK;
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (elig[i]) top_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    enc_d   = enc_q;
    valid_d = valid_q;
    clr     = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (elig != 8'h00) begin
          enc_d   = top_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ACK) begin
          clr     = 8'h01 << enc_q;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // New requests win over a same-cycle clear.
    pend_d = (pend_q & ~clr) | REQ_IN;
  end

  assign ENC_OUT = enc_q;
  assign VALID   = valid_q;
  assign PENDING = pend_q;

endmodule

// File: tb/tb_encoder_8to3_irq.sv
// Self-checking bench for encoder_8to3_irq: directed steps plus
// randomized traffic compared against a behavioural handshake model.
module tb_encoder_8to3_irq;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] REQ_IN;
  logic [7:0] MASK;
  logic       ACK;
  logic [2:0] ENC_OUT;
  logic       VALID;
  logic [7:0] PENDING;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_pend;
  logic       m_valid;
  logic [2:0] m_enc;

  encoder_8to3_irq dut (
    .CLK    (CLK),
    .RST    (RST),
    .REQ_IN (REQ_IN),
    .MASK   (MASK),
    .ACK    (ACK),
    .ENC_OUT(ENC_OUT),
    .VALID  (VALID),
    .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  function automatic logic [2:0] highest(input logic [7:0] v);
    logic [2:0] r;
    logic       found;
    r = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found && v[i]) begin
        r = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a grant is presented once, held until its ACK edge,
  // and only then may its pending bit drop (unless re-requested).
  task automatic model_edge();
    logic [7:0] clr;
    logic [7:0] eligible;
    if (RST) begin
      m_pend = 8'h00;
      m_valid = 1'b0;
      m_enc = 3'd0;
    end else begin
      eligible = m_pend & ~MASK;
      clr = 8'h00;
      if (m_valid && ACK) begin
        clr = 8'h01 << m_enc;
        m_valid = 1'b0;
      end else if (!m_valid && eligible != 8'h00) begin
        m_enc = highest(eligible);
        m_valid = 1'b1;
      end
      m_pend = (m_pend & ~clr) | REQ_IN;
    end
  endtask

  task automatic step(input logic rst, input logic [7:0] req,
                      input logic [7:0] msk, input logic ack);
    @(negedge CLK);
    RST = rst;
    REQ_IN = req;
    MASK = msk;
    ACK = ack;
    @(posedge CLK);
    model_edge();
    #1;
    check("valid", {7'd0, VALID}, {7'd0, m_valid});
    check("pending", PENDING, m_pend);
    if (m_valid) check("enc_out", {5'd0, ENC_OUT}, {5'd0, m_enc});
  endtask

  initial begin
    logic [7:0] dec;
    logic [7:0] onehot;
    RST = 1'b1;
    REQ_IN = 8'hFF;
    MASK = 8'h00;
    ACK = 1'b1;
    m_pend = 8'h00;
    m_valid = 1'b0;
    m_enc = 3'd0;

    // Reset holds everything clear despite requests and ACK.
    step(1'b1, 8'hFF, 8'h00, 1'b1);
    check("rst_enc", {5'd0, ENC_OUT}, 8'h00);
    step(1'b1, 8'hFF, 8'h00, 1'b1);
    check("rst_pend", PENDING, 8'h00);
    check("rst_valid", {7'd0, VALID}, 8'h00);

    // Single request: pending after t, grant after t+1.
    step(1'b0, 8'h20, 8'h00, 1'b0);
    check("single_pend", PENDING, 8'h20);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check("single_enc", {5'd0, ENC_OUT}, 8'h05);
    check("single_valid", {7'd0, VALID}, 8'h01);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("single_ack_pend", PENDING, 8'h00);

    // Priority order with ACK tied high: 7,4,1,0.
    step(1'b0, 8'h93, 8'h00, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    check("prio_7", {5'd0, ENC_OUT}, 8'h07);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 8'h00, 1'b1);
    check("prio_end", PENDING, 8'h00);

    // No pre-emption, then set-wins on the acknowledged line.
    step(1'b0, 8'h04, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 8'h80, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check("no_preempt", {5'd0, ENC_OUT}, 8'h02);
    step(1'b0, 8'h04, 8'h00, 1'b1);
    check("set_wins", PENDING, 8'h84);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check("next_7", {5'd0, ENC_OUT}, 8'h07);
    step(1'b0, 8'h00, 8'h00, 1'b1);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check("again_2", {5'd0, ENC_OUT}, 8'h02);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    // Masking.
    step(1'b0, 8'h0C, 8'h08, 1'b0);
    step(1'b0, 8'h00, 8'h08, 1'b0);
    check("mask_2", {5'd0, ENC_OUT}, 8'h02);
    step(1'b0, 8'h00, 8'h08, 1'b1);
    step(1'b0, 8'h00, 8'h08, 1'b0);
    check("mask_hold", {7'd0, VALID}, 8'h00);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    check("unmask_3", {5'd0, ENC_OUT}, 8'h03);
    step(1'b0, 8'h00, 8'h00, 1'b1);

    // Reset mid-handshake drops VALID and discards pending.
    step(1'b0, 8'h41, 8'h00, 1'b0);
    step(1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 8'h10, 8'h00, 1'b0);
    check("rst_mid_pend", PENDING, 8'h00);

    // Round trip through a 3-to-8 decoder.
    for (int k = 0; k < 8; k++) begin
      onehot = 8'h01 << k;
      step(1'b0, onehot, 8'h00, 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b0);
      dec = 8'h01 << ENC_OUT;
      check("round_trip", VALID ? dec : 8'h00, onehot);
      step(1'b0, 8'h00, 8'h00, 1'b1);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 60) == 0),
           ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
           ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
           1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
